// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer
// Purpose  : Fetch-address sequencer for a pipeline with ID-stage branch
//            resolution and one architectural delay slot. Holds ID while a
//            branch/jr waits for forwarded operands, then redirects fetch.
//            Also keeps saturating conditional-branch statistics.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            ext_stall           - downstream freeze (no state change)
//            id_valid/id_branch/id_jump/id_jr - ID instruction class
//            opnd_ready          - branch/jr operands available
//            judge_res           - branch condition result
//            b_addr/j_addr/jr_addr - branch, jump and register targets
//            pc, pc4             - fetch address and its +4 successor
//            if_en, id_bubble, pc_branch - pipeline control for this cycle
//            state               - RUN=0 / WAIT=1
//            br_total, br_taken  - resolved / taken conditional branches
// Revision : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             opnd_ready,
  input  logic             judge_res,
  input  logic [31:0]      b_addr,
  input  logic [31:0]      j_addr,
  input  logic [31:0]      jr_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             if_en,
  output logic             id_bubble,
  output logic             pc_branch,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] nxt_pc;
  logic [31:0] target;
  logic        ctrl;
  logic        need;
  logic        taken;
  logic        resolve;
  logic        count_br;

  // Instruction classification and redirect target (jr beats j beats branch).
  assign ctrl     = id_valid & (id_branch | id_jump | id_jr);
  assign need     = id_branch | id_jr;
  assign taken    = id_jr | id_jump | (id_branch & judge_res);
  assign target   = id_jr ? jr_addr : (id_jump ? j_addr : b_addr);
  assign resolve  = !ext_stall & ctrl & (!need | opnd_ready);
  // Only pure conditional branches feed the statistics.
  assign count_br = resolve & id_branch & !id_jump & !id_jr;

  assign pc4   = pc + 32'd4;
  assign state = cur_state;

  // Next-state and per-cycle control. RUN and WAIT share the same decision
  // table: the only difference between them is what the state register says.
  always_comb begin
    nxt_state = cur_state;
    nxt_pc    = pc;
    if_en     = 1'b0;
    id_bubble = 1'b0;
    pc_branch = 1'b0;
    if (!reset && !ext_stall) begin
      if (!ctrl) begin
        // Plain sequential fetch; also leaves WAIT if ID was invalidated.
        nxt_state = RUN;
        nxt_pc    = pc4;
        if_en     = 1'b1;
      end else if (!resolve) begin
        // Operands not forwarded yet: hold fetch, bubble EX.
        nxt_state = WAIT;
        id_bubble = 1'b1;
      end else begin
        // Resolve. The delay-slot instruction at pc is fetched this cycle.
        nxt_state = RUN;
        nxt_pc    = taken ? target : pc4;
        if_en     = 1'b1;
        pc_branch = taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= RUN;
      pc        <= RESET_PC;
      br_total  <= '0;
      br_taken  <= '0;
    end else begin
      cur_state <= nxt_state;
      pc        <= nxt_pc;
      if (count_br) begin
        if (br_total != '1) begin
          br_total <= br_total + CNT_ONE;
        end
        if (judge_res && (br_taken != '1)) begin
          br_taken <= br_taken + CNT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_sequencer
// Purpose  : Self-checking bench for branch_sequencer. A driver applies one
//            input vector per cycle, predicts the DUT response from the
//            sequencing rules and queues it; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = 16;
  localparam int          CNT_MAX  = 65535;

  logic             clk = 1'b0;
  logic             reset;
  logic             ext_stall;
  logic             id_valid;
  logic             id_branch;
  logic             id_jump;
  logic             id_jr;
  logic             opnd_ready;
  logic             judge_res;
  logic [31:0]      b_addr;
  logic [31:0]      j_addr;
  logic [31:0]      jr_addr;
  logic [31:0]      pc;
  logic [31:0]      pc4;
  logic             if_en;
  logic             id_bubble;
  logic             pc_branch;
  logic [1:0]       state;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  branch_sequencer #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_stall  (ext_stall),
    .id_valid   (id_valid),
    .id_branch  (id_branch),
    .id_jump    (id_jump),
    .id_jr      (id_jr),
    .opnd_ready (opnd_ready),
    .judge_res  (judge_res),
    .b_addr     (b_addr),
    .j_addr     (j_addr),
    .jr_addr    (jr_addr),
    .pc         (pc),
    .pc4        (pc4),
    .if_en      (if_en),
    .id_bubble  (id_bubble),
    .pc_branch  (pc_branch),
    .state      (state),
    .br_total   (br_total),
    .br_taken   (br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        if_en;
    logic        id_bubble;
    logic        pc_branch;
    logic [1:0]  state;
    int          total;
    int          taken;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference state: the architectural view the DUT should present after
  // each rising edge. Starts at the reset values because the first edge
  // is taken with reset already high.
  logic [31:0] m_pc      = RESET_PC;
  bit          m_waiting = 1'b0;
  int          m_total   = 0;
  int          m_taken   = 0;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
    end
  endfunction

  // Apply one cycle of inputs, queue the expected response for that cycle,
  // then advance the reference through the coming rising edge.
  task automatic drive(input bit rst, input bit stall, input bit valid,
                       input bit br, input bit jmp, input bit jrr,
                       input bit rdy, input bit res,
                       input logic [31:0] ba, input logic [31:0] ja,
                       input logic [31:0] jra);
    exp_t        e;
    bit          is_ctrl;
    bit          go;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    reset      = rst;
    ext_stall  = stall;
    id_valid   = valid;
    id_branch  = br;
    id_jump    = jmp;
    id_jr      = jrr;
    opnd_ready = rdy;
    judge_res  = res;
    b_addr     = ba;
    j_addr     = ja;
    jr_addr    = jra;

    e.pc        = m_pc;
    e.pc4       = m_pc + 32'd4;
    e.state     = m_waiting ? 2'd1 : 2'd0;
    e.total     = m_total;
    e.taken     = m_taken;
    e.if_en     = 1'b0;
    e.id_bubble = 1'b0;
    e.pc_branch = 1'b0;

    if (rst) begin
      m_pc      = RESET_PC;
      m_waiting = 1'b0;
      m_total   = 0;
      m_taken   = 0;
    end else if (!stall) begin
      is_ctrl = valid && (br || jmp || jrr);
      if (!is_ctrl) begin
        e.if_en   = 1'b1;
        m_pc      = m_pc + 32'd4;
        m_waiting = 1'b0;
      end else if ((br || jrr) && !rdy) begin
        e.id_bubble = 1'b1;
        m_waiting   = 1'b1;
      end else begin
        go  = jrr || jmp || (br && res);
        tgt = jrr ? jra : (jmp ? ja : ba);
        e.if_en     = 1'b1;
        e.pc_branch = go;
        m_pc        = go ? tgt : m_pc + 32'd4;
        m_waiting   = 1'b0;
        if (br && !jmp && !jrr) begin
          if (m_total < CNT_MAX) m_total++;
          if (res && m_taken < CNT_MAX) m_taken++;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, $urandom, $urandom, $urandom);
  endtask

  // Conditional branch helper: ready / result / target.
  task automatic beq(input bit rdy, input bit res, input logic [31:0] ba);
    drive(0, 0, 1, 1, 0, 0, rdy, res, ba, $urandom, $urandom);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the queue.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      chk("pc",        pc,                  mon_e.pc);
      chk("pc4",       pc4,                 mon_e.pc4);
      chk("if_en",     {31'd0, if_en},      {31'd0, mon_e.if_en});
      chk("id_bubble", {31'd0, id_bubble},  {31'd0, mon_e.id_bubble});
      chk("pc_branch", {31'd0, pc_branch},  {31'd0, mon_e.pc_branch});
      chk("state",     {30'd0, state},      {30'd0, mon_e.state});
      chk("br_total",  {16'd0, br_total},   mon_e.total[31:0]);
      chk("br_taken",  {16'd0, br_taken},   mon_e.taken[31:0]);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    ext_stall  = 1'b0;
    id_valid   = 1'b0;
    id_branch  = 1'b0;
    id_jump    = 1'b0;
    id_jr      = 1'b0;
    opnd_ready = 1'b0;
    judge_res  = 1'b0;
    b_addr     = '0;
    j_addr     = '0;
    jr_addr    = '0;

    // Reset state, then sequential fetch 0x3000..0x300C.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0, 0, 1, 1, 32'h1234, 0, 0);
    idle(4);

    // beq at pc 0x3010 waiting two cycles, then taken to 0x3040.
    beq(0, 1, 32'h0000_3040);
    beq(0, 1, 32'h0000_3040);
    beq(1, 1, 32'h0000_3040);
    idle(1);

    // jr and j together: jr target wins, counters untouched.
    drive(0, 0, 1, 0, 1, 1, 1, 0, 32'h0000_3300, 32'h0000_3200, 32'h0000_3100);
    idle(1);

    // Stall in WAIT while operands arrive, then resolve (not taken).
    beq(0, 1, 32'h0000_5000);
    drive(0, 1, 1, 1, 0, 0, 1, 1, 32'h0000_5000, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 1, 1, 32'h0000_5000, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 1, 1, 32'h0000_5000, 0, 0);
    beq(1, 0, 32'h0000_5000);
    idle(1);

    // WAIT left because ID was invalidated; plain j; unaligned jr target.
    beq(0, 0, 32'h0000_6000);
    idle(2);
    drive(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_7000, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0000_7003);
    drive(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 32'h0000_7003);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // pc wrap-around.
    drive(0, 0, 1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v, b, j, jr_b, rd, jd;
      r    = ($urandom_range(0, 99) == 0);
      s    = ($urandom_range(0, 7) == 0);
      v    = ($urandom_range(0, 7) != 0);
      b    = ($urandom_range(0, 1) == 1);
      j    = ($urandom_range(0, 3) == 0);
      jr_b = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 1) == 1);
      jd   = ($urandom_range(0, 1) == 1);
      drive(r, s, v, b, j, jr_b, rd, jd, $urandom, $urandom, $urandom);
    end

    // Counter saturation: 0xFFFE taken branches, 3 not-taken, 2 taken.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) beq(1, 1, $urandom);
    for (int i = 0; i < 3; i++) beq(1, 0, $urandom);
    for (int i = 0; i < 2; i++) beq(1, 1, $urandom);
    idle(1);

    // Reset while in WAIT with ext_stall high.
    beq(0, 1, 32'h0000_8000);
    drive(1, 1, 1, 1, 0, 0, 0, 1, 32'h0000_8000, 0, 0);
    idle(2);

    for (int guard = 0; guard < 10 && sb.size() > 0; guard++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
